axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- Shares one AXI read master port (AR + R channels) between two refill requesters: port 0 is the instruction cache, port 1 is the data cache.
- Sits between the L1 cache refill logic and the clock-domain-crossing AR/R FIFO wrappers.
- Replaces the duplicated per-cache read masters.
- Allows one outstanding burst at a time. Arbitration is round-robin, and data beats are routed back to the requester that was granted.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ID_W, 4, AXI ID width
- LEN_W, 4, AXI burst length width (ARLEN = beats-1)
- ID0, 4'd1, ARID issued for port 0
- ID1, 4'd2, ARID issued for port 1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  port 0 read request
- req0_addr  in  ADDR_W  port 0 burst start address
- req0_len  in  LEN_W  port 0 ARLEN value
- req0_ready  out  1  port 0 request accepted (AR handshake done)
- rsp0_valid  out  1  port 0 data beat valid
- rsp0_data  out  DATA_W  port 0 beat data
- rsp0_last  out  1  port 0 final beat
- rsp0_ready  in  1  port 0 beat accept
- req1_valid, req1_addr, req1_len, req1_ready, rsp1_valid, rsp1_data, rsp1_last, rsp1_ready: same widths and meanings as port 0, for port 1
- ARID  out  ID_W  AXI read address ID
- ARADDR  out  ADDR_W  AXI read address
- ARLEN  out  LEN_W  AXI burst length
- ARSIZE  out  3  fixed 3'b010
- ARBURST  out  2  fixed 2'b01 (INCR)
- ARVALID  out  1  AXI address valid
- ARREADY  in  1  AXI address ready
- RID  in  ID_W  AXI read data ID
- RDATA  in  DATA_W  AXI read data
- RRESP  in  2  AXI read response
- RLAST  in  1  AXI last beat
- RVALID  in  1  AXI data valid
- RREADY  out  1  AXI data ready
- err  out  1  sticky protocol error flag

Behaviour:
- Three-state FSM: IDLE, ADDR, DATA. Clock is clk; reset rst is synchronous and active-high.
- On reset:
  - state = IDLE, ARVALID = 0, RREADY = 0.
  - All rspN_valid = 0 and reqN_ready = 0.
  - err = 0, last-grant pointer = 1, so port 0 has priority on the first conflict.
- IDLE:
  - If exactly one reqN_valid is high, grant that port.
  - If both are high, grant the port not granted last time.
  - On grant, register addr, len and ID (ID0 or ID1) into the AR output registers, set ARVALID = 1 the next cycle, go to ADDR, and update the last-grant pointer.
  - Latency: request to ARVALID = 1 cycle.
- ADDR:
  - Hold ARVALID and all AR fields stable until ARREADY.
  - On the ARVALID && ARREADY cycle: pulse the granted reqN_ready for exactly that one cycle, drop ARVALID the next cycle, load beat counter = len, go to DATA.
  - Requester handshake: a requester holds reqN_valid, addr and len until it sees reqN_ready. A requester that drops valid before the grant is ignored; grant is sampled only in IDLE.
- DATA:
  - Combinational pass-through to the granted port only:
    - rspG_valid = RVALID, rspG_data = RDATA, rspG_last = RLAST
    - RREADY = rspG_ready
  - The ungranted port's rsp_valid is held at 0.
  - Each beat where RVALID && RREADY decrements the counter.
  - The beat with RLAST=1 returns the FSM to IDLE on the next cycle. A new grant can be made in that IDLE cycle, so back-to-back bursts have a 1-cycle bubble.
- Outside DATA, RREADY = 0.
- err is set (sticky until reset) when any of the following occurs:
  - a beat with RID ≠ granted ID;
  - RRESP ≠ 2'b00;
  - RLAST=1 while counter ≠ 0;
  - counter = 0 on a beat without RLAST.
- On an error the beat is still forwarded, and the FSM still exits only on RLAST.
- Simultaneous events:
  - A new reqN_valid arriving during ADDR or DATA waits; there is no preemption.
  - Reset in ADDR or DATA aborts immediately: all outputs return to their reset values, and the outstanding burst is abandoned.
- len = 0 (single beat) is legal: the first beat must carry RLAST.

Decomposition:
- Shared package axi_rd_arb_pkg holds:
  - the FSM state enum (IDLE, ADDR, DATA);
  - ARSIZE_WORD = 3'b010 and ARBURST_INCR = 2'b01;
  - RRESP_OKAY = 2'b00.
- One sub-module: rr_arb2, the 2-input round-robin grant logic with the last-grant pointer.

Test Plan:
- Single request:
  - Stimulus: req0 addr=0x0000_0100, len=3, ARREADY held high, 4 beats of RDATA 0xA0..0xA3 with RLAST on the 4th.
  - Response: ARID=1, ARLEN=3, req0_ready pulses once, rsp0 receives 0xA0..0xA3 with rsp0_last on the 4th, rsp1_valid stays 0, err=0.
- Conflict:
  - Stimulus: req0 and req1 asserted in the same cycle straight after reset.
  - Response: port 0 is granted first (ARID=1). After its RLAST, port 1 is granted after the 1-cycle IDLE bubble (ARID=2, its address on ARADDR).
- Fairness:
  - Stimulus: req0 and req1 held high continuously for 4 bursts.
  - Response: grants alternate 0, 1, 0, 1.
- Backpressure:
  - Stimulus: ARREADY low for 5 cycles, then rsp1_ready toggled 1/0 during a len=1 burst.
  - Response: AR fields are stable while ARVALID waits; RREADY follows rsp1_ready; both beats are delivered in order.
- Errors:
  - Stimulus: RID=3 on a port 0 burst, and separately RLAST on beat 2 of a len=3 burst.
  - Response: err=1 and stays 1; the FSM returns to IDLE on RLAST.
- Mid-burst reset:
  - Stimulus: rst asserted in DATA after 1 beat.
  - Response: next cycle state=IDLE, RREADY=0, ARVALID=0, err=0, pointer=1.

Source files
------------

// File: rtl/axi_rd_arb_pkg.sv
// axi_rd_arb_pkg: shared FSM state type and fixed AXI encodings for the read arbiter
package axi_rd_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  localparam logic [2:0] ARSIZE_WORD  = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [1:0] RRESP_OKAY   = 2'b00;
endpackage

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: requester ports plus the shared AXI AR/R master port
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
);
  logic              req0_valid, req0_ready, rsp0_valid, rsp0_last, rsp0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [LEN_W-1:0]  req0_len;
  logic [DATA_W-1:0] rsp0_data;
  logic              req1_valid, req1_ready, rsp1_valid, rsp1_last, rsp1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [LEN_W-1:0]  req1_len;
  logic [DATA_W-1:0] rsp1_data;
  logic [ID_W-1:0]   ARID, RID;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST, RRESP;
  logic              ARVALID, ARREADY, RLAST, RVALID, RREADY, err;
  logic [DATA_W-1:0] RDATA;
  modport master (
    input  req0_valid, req0_addr, req0_len, rsp0_ready,
    input  req1_valid, req1_addr, req1_len, rsp1_ready,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_last,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_last,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY, err
  );
  modport slave (
    output req0_valid, req0_addr, req0_len, rsp0_ready,
    output req1_valid, req1_addr, req1_len, rsp1_ready,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_last,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_last,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY, err
  );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant; last-grant pointer resets to 1 so port 0 wins the first conflict
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic       o_valid,
  output logic       o_gnt
);
  logic r_last;
  always_comb begin
    o_valid = i_en && |i_req;
    o_gnt   = &i_req ? !r_last : i_req[1];
  end
  always_ff @(posedge clk)
    if (rst) r_last <= 1'b1;
    else if (o_valid) r_last <= o_gnt;
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read master between two cache refill ports, one burst in flight
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter logic [ID_W-1:0] ID0 = 4'd1,
  parameter logic [ID_W-1:0] ID1 = 4'd2
) (
  input logic clk,
  input logic rst,
  axi_rd_arbiter_if.master bus
);
  import axi_rd_arb_pkg::*;
  state_t            r_state, w_next;
  logic              r_port, r_err;
  logic [ID_W-1:0]   r_arid;
  logic [ADDR_W-1:0] r_araddr;
  logic [LEN_W-1:0]  r_arlen, r_cnt;
  logic              w_gnt_valid, w_gnt, w_ar_hs, w_beat, w_bad;
  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   ({bus.req1_valid, bus.req0_valid}),
    .i_en    (r_state == IDLE),
    .o_valid (w_gnt_valid),
    .o_gnt   (w_gnt)
  );
  // A beat is bad on ID/response mismatch or when RLAST disagrees with the remaining-beat count
  assign w_bad = bus.RID != r_arid || bus.RRESP != RRESP_OKAY || (bus.RLAST != (r_cnt == '0));
  always_comb begin
    w_ar_hs        = r_state == ADDR && bus.ARREADY;
    bus.RREADY     = r_state == DATA && (r_port ? bus.rsp1_ready : bus.rsp0_ready);
    w_beat         = bus.RVALID && bus.RREADY;
    w_next         = (r_state == IDLE && w_gnt_valid) ? ADDR :
                     w_ar_hs                          ? DATA :
                     (w_beat && bus.RLAST)            ? IDLE : r_state;
    bus.ARVALID    = r_state == ADDR;
    bus.ARID       = r_arid;
    bus.ARADDR     = r_araddr;
    bus.ARLEN      = r_arlen;
    bus.ARSIZE     = ARSIZE_WORD;
    bus.ARBURST    = ARBURST_INCR;
    bus.req0_ready = w_ar_hs && !r_port;
    bus.req1_ready = w_ar_hs && r_port;
    bus.rsp0_valid = r_state == DATA && !r_port && bus.RVALID;
    bus.rsp1_valid = r_state == DATA && r_port && bus.RVALID;
    bus.rsp0_data  = bus.RDATA;
    bus.rsp1_data  = bus.RDATA;
    bus.rsp0_last  = bus.RLAST;
    bus.rsp1_last  = bus.RLAST;
    bus.err        = r_err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_port   <= 1'b0;
      r_err    <= 1'b0;
      r_arid   <= '0;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_gnt_valid) begin
        r_port   <= w_gnt;
        r_arid   <= w_gnt ? ID1 : ID0;
        r_araddr <= w_gnt ? bus.req1_addr : bus.req0_addr;
        r_arlen  <= w_gnt ? bus.req1_len : bus.req0_len;
      end
      if (w_ar_hs) r_cnt <= r_arlen;
      if (w_beat) begin
        r_cnt <= r_cnt - LEN_W'(1);
        r_err <= r_err | w_bad;
      end
    end
  end
endmodule
